merlin_bus_arb: RTL and testbench

MERLIN_BUS_ARB -- requirements
Module: merlin_bus_arb

---
 rtl/merlin_bus_arb.sv | 189 ++++++++++++++++++
 tb/tb_merlin_bus_arb.sv | 281 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/merlin_bus_arb.sv
// -----------------------------------------------------------------------------
// merlin_bus_arb
//   N-to-1 request arbiter with in-order response routing. Requests from the
//   upstream ports are granted round-robin (or fixed priority, see below) onto
//   a single downstream request channel. The granted port index is recorded in
//   an order FIFO so each downstream response is returned to the port that
//   issued the matching request.
//
// Configuration macro:
//   RV_BUSARB_FIXED_PRIO_EN  defined   -> fixed priority, lowest index wins
//                            undefined -> round-robin starting after last grant
//
// Parameters:
//   C_NUM_PORTS     number of upstream requestors (2..8)
//   C_XLEN          address/data width
//   C_FIFO_DEPTH_X  log2 of the order FIFO depth (>= 1)
//
// Ports:
//   clk_i, resetb_i, clk_en_i      clock, async active-low reset, clock enable
//   req*_i / reqready_o            upstream request channel, port p at slice p
//   rsp*_o / rspready_i            upstream response channel (data broadcast)
//   mreq*_o / mreqready_i          downstream request channel
//   mrsp*_i / mrspready_o          downstream response channel
//   outstanding_o                  accepted requests still awaiting a response
// -----------------------------------------------------------------------------
module merlin_bus_arb #(
  parameter int C_NUM_PORTS    = 2,
  parameter int C_XLEN         = 32,
  parameter int C_FIFO_DEPTH_X = 2
) (
  input  logic                        clk_i,
  input  logic                        resetb_i,
  input  logic                        clk_en_i,

  output logic [C_NUM_PORTS-1:0]        reqready_o,
  input  logic [C_NUM_PORTS-1:0]        reqvalid_i,
  input  logic [2*C_NUM_PORTS-1:0]      reqsize_i,
  input  logic [C_NUM_PORTS-1:0]        reqwrite_i,
  input  logic [2*C_NUM_PORTS-1:0]      reqhpl_i,
  input  logic [C_XLEN*C_NUM_PORTS-1:0] reqaddr_i,
  input  logic [C_XLEN*C_NUM_PORTS-1:0] reqdata_i,

  input  logic [C_NUM_PORTS-1:0]      rspready_i,
  output logic [C_NUM_PORTS-1:0]      rspvalid_o,
  output logic                        rsprerr_o,
  output logic                        rspwerr_o,
  output logic [C_XLEN-1:0]           rspdata_o,

  input  logic                        mreqready_i,
  output logic                        mreqvalid_o,
  output logic [1:0]                  mreqsize_o,
  output logic                        mreqwrite_o,
  output logic [1:0]                  mreqhpl_o,
  output logic [C_XLEN-1:0]           mreqaddr_o,
  output logic [C_XLEN-1:0]           mreqdata_o,
  output logic                        mrspready_o,
  input  logic                        mrspvalid_i,
  input  logic                        mrsprerr_i,
  input  logic                        mrspwerr_i,
  input  logic [C_XLEN-1:0]           mrspdata_i,

  output logic [C_FIFO_DEPTH_X:0]     outstanding_o
);

  localparam int PW    = (C_NUM_PORTS > 1) ? $clog2(C_NUM_PORTS) : 1;
  localparam int AW    = C_FIFO_DEPTH_X;
  localparam int DEPTH = 1 << C_FIFO_DEPTH_X;

  logic [PW-1:0]              rr_ptr;
  logic [PW-1:0]              grant;
  logic [PW-1:0]              grant_ofs;
  logic [PW:0]                grant_sum;
  logic [2*C_NUM_PORTS-1:0]   req_rot;
  logic                       any_valid;

  logic [AW:0]                wr_ptr;
  logic [AW:0]                rd_ptr;
  logic [PW-1:0]              order_mem [DEPTH];
  logic [PW-1:0]              head;
  logic                       fifo_full;
  logic                       fifo_empty;
  logic                       push;
  logic                       pop;

  assign any_valid = |reqvalid_i;

  // Rotate the request vector so that index rr_ptr lands at bit 0; the first
  // set bit of the rotated vector is then the offset from rr_ptr to the grant.
  assign req_rot = {reqvalid_i, reqvalid_i} >> rr_ptr;

  // NOTE: every signal assigned in an always_comb gets a default at the top so
  // no path leaves it unassigned, which would otherwise infer a latch.
  always_comb begin
    grant_ofs = '0;
    for (int k = C_NUM_PORTS - 1; k >= 0; k--) begin
      if (req_rot[k]) grant_ofs = PW'(k);
    end
    grant_sum = {1'b0, rr_ptr} + {1'b0, grant_ofs};
    if (grant_sum >= (PW+1)'(C_NUM_PORTS)) begin
      grant_sum = grant_sum - (PW+1)'(C_NUM_PORTS);
    end
    grant = grant_sum[PW-1:0];
  end

  // Order FIFO status: pointers carry one extra MSB so full and empty are
  // distinguishable when the index bits match.
  assign fifo_empty = (wr_ptr == rd_ptr);
  assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                      (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head       = order_mem[rd_ptr[AW-1:0]];

  // Downstream request: granted port's fields; stalled while the FIFO is full
  // because the response could not be routed back otherwise.
  assign mreqvalid_o = any_valid && !fifo_full;

  always_comb begin
    mreqsize_o  = reqsize_i[1:0];
    mreqwrite_o = reqwrite_i[0];
    mreqhpl_o   = reqhpl_i[1:0];
    mreqaddr_o  = reqaddr_i[C_XLEN-1:0];
    mreqdata_o  = reqdata_i[C_XLEN-1:0];
    reqready_o  = '0;
    rspvalid_o  = '0;
    mrspready_o = 1'b0;
    for (int p = 0; p < C_NUM_PORTS; p++) begin
      if (grant == PW'(p)) begin
        mreqsize_o    = reqsize_i[2*p +: 2];
        mreqwrite_o   = reqwrite_i[p];
        mreqhpl_o     = reqhpl_i[2*p +: 2];
        mreqaddr_o    = reqaddr_i[C_XLEN*p +: C_XLEN];
        mreqdata_o    = reqdata_i[C_XLEN*p +: C_XLEN];
        reqready_o[p] = any_valid && mreqready_i && !fifo_full;
      end
      // Responses only route while an order entry exists; otherwise the
      // downstream response is ignored (not accepted).
      if (!fifo_empty && (head == PW'(p))) begin
        rspvalid_o[p] = mrspvalid_i;
        mrspready_o   = rspready_i[p];
      end
    end
  end

  // Response payload is a straight pass-through, broadcast to every port.
  assign rspdata_o = mrspdata_i;
  assign rsprerr_o = mrsprerr_i;
  assign rspwerr_o = mrspwerr_i;

  // mreqvalid_o already excludes the full case, so a pop in the same cycle
  // never lets a push through while full.
  assign push = mreqvalid_o && mreqready_i && clk_en_i;
  assign pop  = mrspvalid_i && mrspready_o && clk_en_i;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or negedge resetb_i) begin
    if (!resetb_i) begin
      rr_ptr        <= '0;
      wr_ptr        <= '0;
      rd_ptr        <= '0;
      outstanding_o <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + 1'b1;
`ifdef RV_BUSARB_FIXED_PRIO_EN
        rr_ptr <= '0;
`else
        rr_ptr <= (grant == PW'(C_NUM_PORTS - 1)) ? '0 : grant + PW'(1);
`endif
      end
      if (pop) begin
        rd_ptr <= rd_ptr + 1'b1;
      end
      case ({push, pop})
        2'b10:   outstanding_o <= outstanding_o + 1'b1;
        2'b01:   outstanding_o <= outstanding_o - 1'b1;
        default: outstanding_o <= outstanding_o;
      endcase
    end
  end

  // NOTE: the order storage is deliberately not reset; the pointers define
  // which entries are live, so stale contents after reset are never read.
  always_ff @(posedge clk_i) begin
    if (push) begin
      order_mem[wr_ptr[AW-1:0]] <= grant;
    end
  end

endmodule

// File: tb/tb_merlin_bus_arb.sv
// -----------------------------------------------------------------------------
// tb_merlin_bus_arb
//   Randomized scoreboard bench for merlin_bus_arb (default parameters).
//   The driver process issues stimulus, computes the expected grant from the
//   arbitration rules and pushes the expected response destination into a
//   queue on each accepted request. A separate monitor process checks the
//   response side on every falling edge against the queue head and pops it on
//   each response handshake.
// -----------------------------------------------------------------------------
module tb_merlin_bus_arb;

  localparam int N     = 2;
  localparam int X     = 32;
  localparam int D     = 2;
  localparam int DEPTH = 1 << D;

  logic               clk_i;
  logic               resetb_i;
  logic               clk_en_i;
  logic [N-1:0]       reqready_o;
  logic [N-1:0]       reqvalid_i;
  logic [2*N-1:0]     reqsize_i;
  logic [N-1:0]       reqwrite_i;
  logic [2*N-1:0]     reqhpl_i;
  logic [X*N-1:0]     reqaddr_i;
  logic [X*N-1:0]     reqdata_i;
  logic [N-1:0]       rspready_i;
  logic [N-1:0]       rspvalid_o;
  logic               rsprerr_o;
  logic               rspwerr_o;
  logic [X-1:0]       rspdata_o;
  logic               mreqready_i;
  logic               mreqvalid_o;
  logic [1:0]         mreqsize_o;
  logic               mreqwrite_o;
  logic [1:0]         mreqhpl_o;
  logic [X-1:0]       mreqaddr_o;
  logic [X-1:0]       mreqdata_o;
  logic               mrspready_o;
  logic               mrspvalid_i;
  logic               mrsprerr_i;
  logic               mrspwerr_i;
  logic [X-1:0]       mrspdata_i;
  logic [D:0]         outstanding_o;

  merlin_bus_arb #(
    .C_NUM_PORTS    (N),
    .C_XLEN         (X),
    .C_FIFO_DEPTH_X (D)
  ) dut (
    .clk_i         (clk_i),
    .resetb_i      (resetb_i),
    .clk_en_i      (clk_en_i),
    .reqready_o    (reqready_o),
    .reqvalid_i    (reqvalid_i),
    .reqsize_i     (reqsize_i),
    .reqwrite_i    (reqwrite_i),
    .reqhpl_i      (reqhpl_i),
    .reqaddr_i     (reqaddr_i),
    .reqdata_i     (reqdata_i),
    .rspready_i    (rspready_i),
    .rspvalid_o    (rspvalid_o),
    .rsprerr_o     (rsprerr_o),
    .rspwerr_o     (rspwerr_o),
    .rspdata_o     (rspdata_o),
    .mreqready_i   (mreqready_i),
    .mreqvalid_o   (mreqvalid_o),
    .mreqsize_o    (mreqsize_o),
    .mreqwrite_o   (mreqwrite_o),
    .mreqhpl_o     (mreqhpl_o),
    .mreqaddr_o    (mreqaddr_o),
    .mreqdata_o    (mreqdata_o),
    .mrspready_o   (mrspready_o),
    .mrspvalid_i   (mrspvalid_i),
    .mrsprerr_i    (mrsprerr_i),
    .mrspwerr_i    (mrspwerr_i),
    .mrspdata_i    (mrspdata_i),
    .outstanding_o (outstanding_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  int checks   = 0;
  int failures = 0;

  // Reference state: expected response destinations in request order,
  // round-robin start index, and an accepted-but-not-yet-applied push.
  int exp_q[$];
  int rr        = 0;
  bit pend      = 1'b0;
  int pend_port = 0;

  // Stimulus knobs, percent probabilities.
  int p_req, p_mrdy, p_mrsp, p_rrdy, p_en;

  task automatic check(input string name, input logic [63:0] act,
                       input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic bit rnd(input int pct);
    return ($urandom_range(99) < pct);
  endfunction

  task automatic set_knobs(input int a, input int b, input int c,
                           input int d, input int e);
    p_req = a; p_mrdy = b; p_mrsp = c; p_rrdy = d; p_en = e;
  endtask

  task automatic drive_inputs();
    for (int p = 0; p < N; p++) begin
      reqvalid_i[p]          = rnd(p_req);
      reqwrite_i[p]          = 1'($urandom_range(1));
      reqsize_i[2*p +: 2]    = 2'($urandom_range(3));
      reqhpl_i[2*p +: 2]     = 2'($urandom_range(3));
      reqaddr_i[X*p +: X]    = $urandom;
      reqdata_i[X*p +: X]    = $urandom;
      rspready_i[p]          = rnd(p_rrdy);
    end
    mreqready_i = rnd(p_mrdy);
    mrspvalid_i = rnd(p_mrsp);
    mrsprerr_i  = 1'($urandom_range(1));
    mrspwerr_i  = 1'($urandom_range(1));
    mrspdata_i  = rnd(50) ? 32'hA5A5_A5A5 : $urandom;
    clk_en_i    = rnd(p_en);
  endtask

  // One clock of the driver: commit the previous accepted request, drive new
  // inputs, then check the request side against the arbitration rules.
  task automatic cycle();
    int gp;
    bit any;
    bit full;
    logic [N-1:0] exp_ready;
    @(posedge clk_i);
    #1;
    if (pend) begin
      exp_q.push_back(pend_port);
`ifdef RV_BUSARB_FIXED_PRIO_EN
      rr = 0;
`else
      rr = (pend_port + 1) % N;
`endif
      pend = 1'b0;
    end
    drive_inputs();
    #2;
    any  = (reqvalid_i != '0);
    full = (exp_q.size() == DEPTH);
    gp   = 0;
    for (int k = N - 1; k >= 0; k--) begin
      if (reqvalid_i[(rr + k) % N]) gp = (rr + k) % N;
    end
    exp_ready = '0;
    if (any && mreqready_i && !full) exp_ready[gp] = 1'b1;
    check("outstanding", 64'(outstanding_o), 64'(exp_q.size()));
    check("mreqvalid", 64'(mreqvalid_o), 64'(any && !full));
    check("reqready", 64'(reqready_o), 64'(exp_ready));
    if (any) begin
      check("mreqaddr",  64'(mreqaddr_o),  64'(reqaddr_i[X*gp +: X]));
      check("mreqdata",  64'(mreqdata_o),  64'(reqdata_i[X*gp +: X]));
      check("mreqsize",  64'(mreqsize_o),  64'(reqsize_i[2*gp +: 2]));
      check("mreqhpl",   64'(mreqhpl_o),   64'(reqhpl_i[2*gp +: 2]));
      check("mreqwrite", 64'(mreqwrite_o), 64'(reqwrite_i[gp]));
    end
    if (any && !full && mreqready_i && clk_en_i) begin
      pend      = 1'b1;
      pend_port = gp;
    end
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  // Reset while requests are in flight: outstanding clears without a clock
  // and a late downstream response must not be accepted or routed.
  task automatic reset_mid_op();
    clk_en_i   = 1'b0;
    reqvalid_i = '0;
    resetb_i   = 1'b0;
    exp_q.delete();
    pend = 1'b0;
    rr   = 0;
    #1;
    check("rst_async_outstanding", 64'(outstanding_o), 64'd0);
    mrspvalid_i = 1'b1;
    rspready_i  = '1;
    #1;
    check("rst_late_mrspready", 64'(mrspready_o), 64'd0);
    check("rst_late_rspvalid", 64'(rspvalid_o), 64'd0);
    @(posedge clk_i);
    #1;
    resetb_i = 1'b1;
  endtask

  // Response-side monitor: scoreboard head decides where a response must go.
  initial begin
    forever begin
      @(negedge clk_i);
      check("rspdata", 64'(rspdata_o), 64'(mrspdata_i));
      check("rsperr", 64'({rsprerr_o, rspwerr_o}), 64'({mrsprerr_i, mrspwerr_i}));
      if (exp_q.size() == 0) begin
        check("rspvalid_empty", 64'(rspvalid_o), 64'd0);
        check("mrspready_empty", 64'(mrspready_o), 64'd0);
      end else begin
        int h;
        logic [N-1:0] exp_v;
        h     = exp_q[0];
        exp_v = '0;
        if (mrspvalid_i) exp_v[h] = 1'b1;
        check("rspvalid", 64'(rspvalid_o), 64'(exp_v));
        check("mrspready", 64'(mrspready_o), 64'(rspready_i[h]));
        if (mrspvalid_i && rspready_i[h] && clk_en_i) void'(exp_q.pop_front());
      end
    end
  end

  initial begin
    resetb_i    = 1'b0;
    clk_en_i    = 1'b1;
    reqvalid_i  = '0;
    reqsize_i   = '0;
    reqwrite_i  = '0;
    reqhpl_i    = '0;
    reqaddr_i   = '0;
    reqdata_i   = '0;
    rspready_i  = '0;
    mreqready_i = 1'b0;
    mrspvalid_i = 1'b0;
    mrsprerr_i  = 1'b0;
    mrspwerr_i  = 1'b0;
    mrspdata_i  = '0;
    set_knobs(0, 0, 0, 0, 100);
    #2;
    check("reset_outstanding", 64'(outstanding_o), 64'd0);
    check("reset_mreqvalid", 64'(mreqvalid_o), 64'd0);
    check("reset_mrspready", 64'(mrspready_o), 64'd0);
    check("reset_rspvalid", 64'(rspvalid_o), 64'd0);
    #10;
    resetb_i = 1'b1;

    // Both ports always requesting with everything ready: grants alternate.
    set_knobs(100, 100, 100, 100, 100);
    run(12);
    // No responses: FIFO fills, then requests stall despite valid.
    set_knobs(100, 100, 0, 0, 100);
    run(8);
    // Full FIFO with a response and a request together: pop only.
    set_knobs(100, 100, 100, 100, 100);
    run(3);
    // Clock enable low: nothing moves.
    set_knobs(100, 100, 100, 100, 0);
    run(5);
    // Mixed random traffic.
    set_knobs(60, 70, 60, 70, 85);
    run(400);
    // Drain, build two outstanding, then reset mid-operation.
    set_knobs(0, 100, 100, 100, 100);
    run(8);
    set_knobs(100, 100, 0, 0, 100);
    run(2);
    set_knobs(0, 100, 0, 0, 100);
    run(1);
    check("pre_reset_outstanding", 64'(outstanding_o), 64'd2);
    reset_mid_op();
    set_knobs(70, 60, 60, 60, 80);
    run(300);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
